ram_sp_param: RTL

- Parametrised single-port synchronous RAM; next generation of the team's 32x32 RAM.
- Adds configurable data width and depth, byte-enable writes, and selectable read latency (1 or 2 cycles) with a valid strobe.
- Adds a hardware clear sequencer that zero-fills the array one word per cycle.
- Sits behind the bus interface as the generic data store.

---
 rtl/ram_sp_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with byte enables,
// 1/2-cycle read latency and a zero-fill clear sequencer.
module ram_sp_param #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wen,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          clr_done
);

  localparam int NB = DW / 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_mem [DEPTH];
  logic            r_v1;
  logic [DW-1:0]   r_d1;

  logic w_inr;
  logic w_acc;
  logic w_wr;
  logic w_rd;
  logic w_last;
  logic w_clr_wr;

  // Extra top bit keeps the bound check correct when DEPTH == 2**AW.
  assign w_inr    = ({1'b0, addr} < (AW+1)'(DEPTH));
  assign w_acc    = rst_n && (r_state == IDLE) && !clr && cen;
  assign w_wr     = w_acc && wen && w_inr;
  assign w_rd     = w_acc && !wen;
  assign w_last   = (r_ptr == AW'(DEPTH - 1));
  assign w_clr_wr = rst_n && (r_state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
      endcase
    end
  end

  // Array has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) begin
          r_mem[addr][8*k +: 8] <= din[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd;
      r_d1 <= (w_rd && w_inr) ? r_mem[addr] : '0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic          r_v2;
      logic [DW-1:0] r_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          r_d2 <= r_d1;
        end
      end

      assign dout       = r_d2;
      assign dout_valid = r_v2;
    end else begin : g_lat1
      assign dout       = r_d1;
      assign dout_valid = r_v1;
    end
  endgenerate

  assign busy     = r_busy;
  assign clr_done = r_done;

endmodule
